traffic_light_controller: RTL
=============================

# traffic_light_controller

Main-road traffic light sequencer sitting directly downstream of the one-hot input-pattern detector FSM: it consumes that detector's single-cycle detection pulse as a pedestrian/crossing request. It holds main-road Green for a guaranteed minimum time, then sequences Yellow and Red+Walk with cycle-exact counters before returning to Green. Requests are latched, so none are lost while a crossing cycle is in progress.

## Interface
- GREEN_MIN, 10: minimum Green dwell in cycles, range 1..2**CW-1
- YELLOW_TIME, 3: Yellow dwell in cycles, range 1..2**CW-1
- RED_TIME, 6: Red/Walk dwell in cycles, range 1..2**CW-1; must be ≥5 when WALK_FLASH_EN is defined
- CW, 8: timer width in bits
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- Din  input  1  request pulse from the upstream detector (Dout); any high sample counts
- Green  output  1  main-road green
- Yellow  output  1  main-road yellow
- Red  output  1  main-road red
- Walk  output  1  pedestrian walk
- Busy  output  1  high when a request is pending or a crossing cycle is in progress

## Operation
- State register is one-hot, 3 bits: GREEN=3'b001, YELLOW=3'b010, RED=3'b100. Any other value returns to GREEN at the next edge with the timer cleared.
- Timer, CW bits: cleared on every state change and by reset.
  - GREEN: increments each cycle and saturates at GREEN_MIN-1.
  - YELLOW/RED: increments each cycle.
- pending flag, 1 bit: set at any edge where Din=1, except the GREEN→YELLOW edge. It is cleared at the GREEN→YELLOW edge, so a Din high on that same edge is absorbed.
- Transitions (evaluated at the rising edge):
  - GREEN→YELLOW when timer==GREEN_MIN-1 and pending==1; otherwise stay in GREEN indefinitely.
  - YELLOW→RED when timer==YELLOW_TIME-1.
  - RED→GREEN when timer==RED_TIME-1.
- Outputs are Moore decodes of the state register:
  - Green=GREEN, Yellow=YELLOW, Red=RED.
  - Walk=RED, subject to the WALK_FLASH_EN behaviour below.
  - Busy = pending OR (state≠GREEN).
- Requests arriving in YELLOW or RED set pending. They are served on the next cycle once the Green minimum is met; no second Din is needed.

## Timing
- Reset (Reset=0), asynchronous and effective immediately, mid-operation included:
  - state=GREEN, timer=0, pending=0.
  - Green=1, Yellow=0, Red=0, Walk=0, Busy=0.
- Release is synchronous to the first rising edge with Reset=1.
- Green dwell is exactly GREEN_MIN cycles when a request is already pending. Yellow is exactly YELLOW_TIME cycles and Red exactly RED_TIME cycles.
- Request latency with the Green minimum already met: Din sampled at edge k → pending=1 after edge k → Yellow=1 after edge k+1. Yellow rises 2 cycles after Din rises.
- Exactly one of Green/Yellow/Red is high in every cycle after reset.

## Configuration
- WALK_FLASH_EN defined:
  - During RED, Walk=1 for the first RED_TIME-4 cycles.
  - In the last 4 cycles of RED, Walk = 0,1,0,1 (Walk = timer[0] of the RED timer offset, i.e. the pattern ends high).
  - Outside RED, Walk=0.
- WALK_FLASH_EN undefined: Walk=1 for every RED cycle and 0 otherwise. No flash logic is synthesised.

## Test plan
- Reset release, then a 1-cycle Din pulse 2 cycles later (defaults) → Green for exactly 10 cycles from release, Yellow 3, Red+Walk 6, then Green with Busy=0 held indefinitely.
- Din pulse 30 cycles into Green → Busy rises 1 cycle after Din; Yellow rises exactly 2 cycles after Din.
- Din pulse during the 4th Red cycle → after Red, Green lasts exactly 10 cycles and a second crossing cycle starts with no new Din; Busy stays 1 throughout.
- Din high on the GREEN→YELLOW edge only → absorbed; after Red, Green holds indefinitely and Busy=0.
- Reset driven low during the 2nd Yellow cycle → Green=1, Yellow=0, Busy=0 before the next edge; after release, Green holds with no Din.
- RED_TIME=6 with WALK_FLASH_EN defined → Walk per Red cycle 1,1,0,1,0,1; with it undefined → 1,1,1,1,1,1.

Source files
------------

// File: rtl/traffic_light_controller_if.sv
// -----------------------------------------------------------------------------
// traffic_light_controller_if
//   Groups the request input and the light outputs of the main-road traffic
//   light controller.
//
//   Signals:
//     din    - request pulse from the upstream pattern detector
//     green  - main-road green
//     yellow - main-road yellow
//     red    - main-road red
//     walk   - pedestrian walk
//     busy   - request pending or crossing cycle in progress
//
//   Modports:
//     master - request source / light observer (drives din)
//     slave  - the controller (drives the lights and busy)
// -----------------------------------------------------------------------------
interface traffic_light_controller_if;
  logic din;
  logic green;
  logic yellow;
  logic red;
  logic walk;
  logic busy;

  modport master (
    output din,
    input  green, yellow, red, walk, busy
  );

  modport slave (
    input  din,
    output green, yellow, red, walk, busy
  );
endinterface : traffic_light_controller_if

// File: rtl/traffic_light_controller.sv
// -----------------------------------------------------------------------------
// traffic_light_controller
//   Main-road light sequencer. A request pulse (din) is latched into a pending
//   flag; once Green has been held for at least GREEN_MIN cycles a pending
//   request starts a crossing cycle: YELLOW_TIME cycles of Yellow followed by
//   RED_TIME cycles of Red+Walk, then back to Green.
//
//   Ports:
//     clk_i   - rising-edge clock
//     rst_ni  - asynchronous active-low reset
//     tl_if   - slave modport: din in; green/yellow/red/walk/busy out
//
//   Parameters:
//     GREEN_MIN   - minimum Green dwell in cycles (1..2**CW-1)
//     YELLOW_TIME - Yellow dwell in cycles (1..2**CW-1)
//     RED_TIME    - Red/Walk dwell in cycles (1..2**CW-1, >=5 with flash)
//     CW          - timer width in bits
//
//   Build option:
//     WALK_FLASH_EN - when defined, Walk flashes 0,1,0,1 over the last four
//                     Red cycles; otherwise Walk is steady for all of Red.
// -----------------------------------------------------------------------------
module traffic_light_controller #(
  parameter int unsigned GREEN_MIN   = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned RED_TIME    = 6,
  parameter int unsigned CW          = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  traffic_light_controller_if.slave    tl_if
);

  typedef enum logic [2:0] {
    S_GREEN  = 3'b001,
    S_YELLOW = 3'b010,
    S_RED    = 3'b100
  } state_e;

  localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TIME - 1);
  localparam logic [CW-1:0] RED_LAST    = CW'(RED_TIME - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          go_yellow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_GREEN;
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    go_yellow = 1'b0;

    case (state_q)
      S_GREEN: begin
        // Timer saturates at the minimum so Green can hold indefinitely and
        // still react to a request on the very next edge.
        if (timer_q == GREEN_LAST) begin
          if (pending_q) begin
            go_yellow = 1'b1;
            state_d   = S_YELLOW;
            timer_d   = '0;
          end
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      S_YELLOW: begin
        if (timer_q == YELLOW_LAST) begin
          state_d = S_RED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      S_RED: begin
        if (timer_q == RED_LAST) begin
          state_d = S_GREEN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      default: begin
        // Corrupted one-hot code: recover to Green with a fresh timer.
        state_d = S_GREEN;
        timer_d = '0;
      end
    endcase

    // The request being served is consumed on the GREEN->YELLOW edge; a din
    // coinciding with that edge is absorbed into the same crossing cycle.
    pending_d = pending_q;
    if (go_yellow) begin
      pending_d = 1'b0;
    end else if (tl_if.din) begin
      pending_d = 1'b1;
    end
  end

  assign tl_if.green  = (state_q == S_GREEN);
  assign tl_if.yellow = (state_q == S_YELLOW);
  assign tl_if.red    = (state_q == S_RED);
  assign tl_if.busy   = pending_q | (state_q != S_GREEN);

`ifdef WALK_FLASH_EN
  localparam logic [CW-1:0] FLASH_START = CW'(RED_TIME - 4);

  // Within the flash window the LSB of (timer - FLASH_START) gives 0,1,0,1;
  // the LSB of a difference is just the XOR of the operand LSBs.
  logic walk_red;
  assign walk_red   = (timer_q < FLASH_START) ? 1'b1
                                              : (timer_q[0] ^ FLASH_START[0]);
  assign tl_if.walk = (state_q == S_RED) & walk_red;
`else
  assign tl_if.walk = (state_q == S_RED);
`endif

endmodule : traffic_light_controller
